// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the framed UART loader: frame and receiver
// state encodings, frame start marker and maximum payload length.
package uart_frame_pkg;

  typedef enum logic [3:0] {
    IDLE, SYNC, LEN_H, LEN_L, DATA, CHK, DONE, ERR, WAIT_LOW
  } frame_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned MAX_LEN   = 2448;

endpackage

// File: rtl/uart_frame_loader_if.sv
// Sequencer handshake and RAM write port of the frame loader.
// The loader side is master; the sequencer/RAM side is slave.
interface uart_frame_loader_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              start;
  logic [7:0]        ram_din;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              done;
  logic              err;
  logic [15:0]       rx_len;

  modport master (input start, output ram_din, ram_addr, ram_we, done, err, rx_len);
  modport slave  (output start, input ram_din, ram_addr, ram_we, done, err, rx_len);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF input synchronizer, mid-bit sampling baud counter
// and LSB-first shifter. byte_valid pulses one cycle after the stop sample.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_ok
);
  import uart_frame_pkg::*;

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);

  rx_state_t      state;
  logic [1:0]     sync_ff;
  logic           rx;
  logic           rx_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  assign rx = sync_ff[1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_ff    <= '1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_ok   <= 1'b0;
    end else begin
      sync_ff    <= {sync_ff[0], rxd};
      rx_prev    <= rx;
      byte_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          // Half-bit recheck: a line already high again was a glitch.
          if (cnt == CW'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shreg <= {rx, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt        <= '0;
            byte_valid <= 1'b1;
            byte_data  <= shreg;
            frame_ok   <= rx;
            state      <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// Framed UART loader: SYNC, big-endian length, payload written to RAM at
// consecutive addresses, XOR checksum; reports done/err to the sequencer.
module uart_frame_loader #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned MAX_LEN   = uart_frame_pkg::MAX_LEN,
  parameter logic [7:0]  SYNC_BYTE = uart_frame_pkg::SYNC_BYTE
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                uart_rxd,
  uart_frame_loader_if.master bus
);
  import uart_frame_pkg::*;

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

  frame_state_t      state;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              frame_ok;
  logic [7:0]        len_hi;
  logic [15:0]       len_w;
  logic [15:0]       rx_len_q;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        chk;
  logic              last_byte;
  logic [7:0]        ram_din_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic              done_q;
  logic              err_q;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .rxd        (uart_rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_ok   (frame_ok)
  );

  assign len_w     = {len_hi, byte_data};
  assign last_byte = (16'(idx) == rx_len_q - 16'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      len_hi     <= '0;
      rx_len_q   <= '0;
      idx        <= '0;
      chk        <= '0;
      ram_din_q  <= '0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      // Losing start mid-frame takes priority over any byte arriving that cycle.
      if (!bus.start && (state inside {SYNC, LEN_H, LEN_L, DATA, CHK})) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (bus.start) state <= SYNC;
          SYNC: begin
            if (byte_valid && frame_ok && byte_data == SYNC_BYTE) state <= LEN_H;
          end
          LEN_H: begin
            if (byte_valid) begin
              if (!frame_ok) begin
                state <= ERR; done_q <= 1'b1; err_q <= 1'b1;
              end else begin
                len_hi <= byte_data;
                state  <= LEN_L;
              end
            end
          end
          LEN_L: begin
            if (byte_valid) begin
              if (!frame_ok) begin
                state <= ERR; done_q <= 1'b1; err_q <= 1'b1;
              end else begin
                rx_len_q <= len_w;
                if (len_w == 16'd0 || len_w > 16'(MAX_LEN)) begin
                  state <= ERR; done_q <= 1'b1; err_q <= 1'b1;
                end else begin
                  chk   <= '0;
                  idx   <= '0;
                  state <= DATA;
                end
              end
            end
          end
          DATA: begin
            if (byte_valid) begin
              if (!frame_ok) begin
                state <= ERR; done_q <= 1'b1; err_q <= 1'b1;
              end else begin
                ram_din_q  <= byte_data;
                ram_addr_q <= idx;
                ram_we_q   <= 1'b1;
                chk        <= chk ^ byte_data;
                if (last_byte) state <= CHK;
                else idx <= idx + 1'b1;
              end
            end
          end
          CHK: begin
            if (byte_valid) begin
              done_q <= 1'b1;
              if (frame_ok && byte_data == chk) begin
                state <= DONE;
              end else begin
                state <= ERR;
                err_q <= 1'b1;
              end
            end
          end
          DONE, ERR: state <= WAIT_LOW;
          WAIT_LOW:  if (!bus.start) state <= IDLE;
          default:   state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ram_din  = ram_din_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rx_len   = rx_len_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: directed and random frames are
// parsed by a queue-based frame model and compared with observed writes/done.
module tb_uart_frame_loader;

  localparam int CPB = 10;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic uart_rxd  = 1'b1;

  uart_frame_loader_if #(.ADDR_W(15)) bus ();

  uart_frame_loader #(
    .CLK_FREQ  (1000),
    .BAUD      (100),
    .ADDR_W    (15),
    .MAX_LEN   (2448),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // observed traffic
  logic [22:0] got_wr[$];
  bit          got_err[$];
  int          we_double = 0;
  logic        prev_we   = 1'b0;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (bus.ram_we) got_wr.push_back({bus.ram_addr, bus.ram_din});
      if (bus.done) got_err.push_back(bus.err);
      if (bus.ram_we && prev_we) we_double++;
      prev_we = bus.ram_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  // stimulus bytes and reference-model expectations
  logic [7:0]  m_b[$];
  bit          m_ok[$];
  logic [22:0] exp_wr[$];
  int          exp_done;
  bit          exp_err;
  logic [15:0] exp_len = '0;

  function automatic void push(input logic [7:0] b, input bit ok);
    m_b.push_back(b);
    m_ok.push_back(ok);
  endfunction

  // Parses the byte stream by the frame rules, assuming start stays high.
  function automatic void model();
    int n = m_b.size();
    int i = 0;
    logic [15:0] len;
    logic [7:0]  chk;
    exp_wr.delete();
    exp_done = 0;
    exp_err  = 1'b0;
    while (i < n && !(m_ok[i] && m_b[i] == 8'hA5)) i++;
    i++;
    if (i >= n) return;
    if (!m_ok[i]) begin exp_done = 1; exp_err = 1'b1; return; end
    len[15:8] = m_b[i];
    i++;
    if (i >= n) return;
    if (!m_ok[i]) begin exp_done = 1; exp_err = 1'b1; return; end
    len[7:0] = m_b[i];
    exp_len  = len;
    i++;
    if (len == 16'd0 || len > 16'd2448) begin exp_done = 1; exp_err = 1'b1; return; end
    chk = 8'h00;
    for (int k = 0; k < int'(len); k++) begin
      if (i >= n) return;
      if (!m_ok[i]) begin exp_done = 1; exp_err = 1'b1; return; end
      exp_wr.push_back({15'(k), m_b[i]});
      chk = chk ^ m_b[i];
      i++;
    end
    if (i >= n) return;
    exp_done = 1;
    exp_err  = !(m_ok[i] && m_b[i] == chk);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge sys_clk) uart_rxd = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge sys_clk);
    end
    uart_rxd = stop_ok;
    repeat (CPB) @(negedge sys_clk);
    uart_rxd = 1'b1;
    if (!stop_ok) repeat (CPB) @(negedge sys_clk);
  endtask

  task automatic play_frame();
    got_wr.delete();
    got_err.delete();
    we_double = 0;
    bus.start = 1'b1;
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < m_b.size(); i++) begin
      send_byte(m_b[i], m_ok[i]);
      repeat ($urandom_range(0, 15)) @(negedge sys_clk);
    end
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic end_frame();
    bus.start = 1'b0;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus.ram_din, bus.ram_addr, bus.ram_we, bus.done, bus.err, bus.rx_len} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: din=%h addr=%h we=%b done=%b err=%b len=%h, required all 0",
               bus.ram_din, bus.ram_addr, bus.ram_we, bus.done, bus.err, bus.rx_len);
    end
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_directed_frames();
    for (int f = 0; f < 6; f++) begin
      m_b.delete();
      m_ok.delete();
      case (f)
        0: begin push(8'hA5,1); push(8'h00,1); push(8'h03,1); push(8'h11,1);
                 push(8'h22,1); push(8'h33,1); push(8'h00,1); end
        1: begin push(8'hA5,1); push(8'h00,1); push(8'h02,1); push(8'h0F,1);
                 push(8'hF0,1); push(8'h01,1); end
        2: begin push(8'h3C,1); push(8'h5A,1); push(8'hA5,1); push(8'h00,1);
                 push(8'h01,1); push(8'h7E,1); push(8'h7E,1); end
        3: begin push(8'hA5,1); push(8'h00,1); push(8'h00,1); end
        4: begin push(8'hA5,1); push(8'h09,1); push(8'h91,1); end
        default: begin push(8'hA5,1); push(8'h00,1); push(8'h02,1);
                       push(8'h12,1); push(8'h34,0); end
      endcase
      model();
      play_frame();
      checks++;
      if (got_wr.size() !== exp_wr.size()) begin
        errors++;
        $display("FAIL dir%0d_write_count: got %0d required %0d", f, got_wr.size(), exp_wr.size());
      end
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
        checks++;
        if (got_wr[i] !== exp_wr[i]) begin
          errors++;
          $display("FAIL dir%0d_write%0d: got addr %h data %h required addr %h data %h",
                   f, i, got_wr[i][22:8], got_wr[i][7:0], exp_wr[i][22:8], exp_wr[i][7:0]);
        end
      end
      checks++;
      if (got_err.size() !== exp_done) begin
        errors++;
        $display("FAIL dir%0d_done_count: got %0d required %0d", f, got_err.size(), exp_done);
      end else if (exp_done == 1) begin
        checks++;
        if (got_err[0] !== exp_err) begin
          errors++;
          $display("FAIL dir%0d_err: got %b required %b", f, got_err[0], exp_err);
        end
      end
      checks++;
      if (bus.rx_len !== exp_len) begin
        errors++;
        $display("FAIL dir%0d_rx_len: got %h required %h", f, bus.rx_len, exp_len);
      end
      checks++;
      if (we_double !== 0) begin
        errors++;
        $display("FAIL dir%0d_we_width: got %0d multi-cycle strobes required 0", f, we_double);
      end
      end_frame();
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    logic [7:0] chk;
    int len;
    for (int f = 0; f < 8; f++) begin
      m_b.delete();
      m_ok.delete();
      for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
        do b = 8'($urandom); while (b == 8'hA5);
        push(b, 1'b1);
      end
      push(8'hA5, 1'b1);
      len = int'($urandom_range(1, 5));
      push(8'h00, $urandom_range(0, 19) != 0);
      push(8'(len), $urandom_range(0, 19) != 0);
      chk = 8'h00;
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        chk = chk ^ b;
        push(b, $urandom_range(0, 19) != 0);
      end
      if ($urandom_range(0, 2) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      push(chk, 1'b1);
      model();
      play_frame();
      checks++;
      if (got_wr.size() !== exp_wr.size()) begin
        errors++;
        $display("FAIL rnd%0d_write_count: got %0d required %0d", f, got_wr.size(), exp_wr.size());
      end
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
        checks++;
        if (got_wr[i] !== exp_wr[i]) begin
          errors++;
          $display("FAIL rnd%0d_write%0d: got %h required %h", f, i, got_wr[i], exp_wr[i]);
        end
      end
      checks++;
      if (got_err.size() !== exp_done) begin
        errors++;
        $display("FAIL rnd%0d_done_count: got %0d required %0d", f, got_err.size(), exp_done);
      end else if (exp_done == 1) begin
        checks++;
        if (got_err[0] !== exp_err) begin
          errors++;
          $display("FAIL rnd%0d_err: got %b required %b", f, got_err[0], exp_err);
        end
      end
      checks++;
      if (bus.rx_len !== exp_len) begin
        errors++;
        $display("FAIL rnd%0d_rx_len: got %h required %h", f, bus.rx_len, exp_len);
      end
      end_frame();
    end
  endtask

  task automatic test_abort();
    m_b.delete();
    m_ok.delete();
    push(8'hA5,1); push(8'h00,1); push(8'h05,1); push(8'h01,1); push(8'h02,1);
    model();
    play_frame();
    bus.start = 1'b0;
    repeat (5) @(negedge sys_clk);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    repeat (10) @(negedge sys_clk);
    checks++;
    if (got_wr.size() !== exp_wr.size()) begin
      errors++;
      $display("FAIL abort_write_count: got %0d required %0d", got_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin
        errors++;
        $display("FAIL abort_write%0d: got %h required %h", i, got_wr[i], exp_wr[i]);
      end
    end
    checks++;
    if (got_err.size() !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses required 0", got_err.size());
    end
  endtask

  task automatic test_reset_mid();
    m_b.delete();
    m_ok.delete();
    push(8'hA5,1); push(8'h00,1); push(8'h03,1); push(8'h11,1);
    model();
    play_frame();
    checks++;
    if (bus.rx_len !== exp_len) begin
      errors++;
      $display("FAIL midrst_len_before: got %h required %h", bus.rx_len, exp_len);
    end
    fork
      send_byte(8'h22, 1'b1);
      begin
        repeat (40) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ram_din, bus.ram_addr, bus.ram_we, bus.done, bus.err, bus.rx_len} !== '0) begin
          errors++;
          $display("FAIL midrst_outputs: din=%h addr=%h we=%b done=%b err=%b len=%h, required all 0",
                   bus.ram_din, bus.ram_addr, bus.ram_we, bus.done, bus.err, bus.rx_len);
        end
      end
    join
    bus.start = 1'b0;
    exp_len   = '0;
    repeat (2 * CPB) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    m_b.delete();
    m_ok.delete();
    push(8'hA5,1); push(8'h00,1); push(8'h02,1); push(8'h5C,1); push(8'hC3,1); push(8'h9F,1);
    model();
    play_frame();
    checks++;
    if (got_wr.size() !== exp_wr.size()) begin
      errors++;
      $display("FAIL post_rst_write_count: got %0d required %0d", got_wr.size(), exp_wr.size());
    end
    checks++;
    if (got_err.size() !== 1 || got_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_done: got %0d pulses required 1 with err 0", got_err.size());
    end
    end_frame();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_directed_frames();
    test_random_frames();
    test_abort();
    end_frame();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Framed UART receiver that sits upstream of the input RAM. Under a level start from the top-level sequencer, it deserializes 8N1 bytes from uart_rxd and validates a header/length/checksum frame. Each payload byte is written into the input RAM at consecutive addresses. It reports completion and frame errors so the sequencer can advance to the RAM-read/sign stage or retry.

## Interface
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- BAUD, 115200: UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide).
- ADDR_W, 15: RAM address width.
- MAX_LEN, 2448: maximum legal payload length in bytes (19584/8).
- SYNC_BYTE, 8'hA5: frame start marker.
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; high enables reception, sequencer holds it until done.
- uart_rxd  in  1  asynchronous serial input, idle high.
- ram_din  out  8  payload byte to RAM.
- ram_addr  out  ADDR_W  write address, 0-based payload index.
- ram_we  out  1  one-cycle write strobe.
- done  out  1  one-cycle pulse: frame finished (good or bad).
- err  out  1  valid with done: 1 means the frame was rejected.
- rx_len  out  16  payload length from the header; held until the next frame.

## Operation
- uart_rxd passes through a 2-FF synchronizer; all logic uses the synchronized value.
- Byte receiver:
  - Detects a falling edge while idle, waits CLKS_PER_BIT/2 cycles, and rechecks low; a high there is a glitch and the receiver returns to idle.
  - Then samples 8 data bits LSB first, each CLKS_PER_BIT apart, then the stop bit.
  - Emits byte_valid for one cycle with byte_data and frame_ok (stop bit == 1).
- Frame FSM states:
  - IDLE: when start == 1, go to SYNC.
  - SYNC: a byte equal to SYNC_BYTE goes to LEN_H. Other bytes are discarded; stay in SYNC.
  - LEN_H / LEN_L: capture length, big-endian, into rx_len. At LEN_L, len == 0 or len > MAX_LEN goes to ERR; otherwise clear the checksum and go to DATA.
  - DATA: each byte drives ram_din = byte, ram_addr = idx, ram_we = 1, then chk ^= byte and idx++. After idx reaches len-1, go to CHK.
  - CHK: received byte == chk goes to DONE, else ERR.
  - DONE / ERR: pulse done (err = 1 in ERR) for one cycle, then go to WAIT_LOW.
  - WAIT_LOW: stay until start == 0, then go to IDLE.
- A stop-bit error on any byte in LEN_H..CHK goes to ERR. In SYNC, a stop-bit error byte is simply discarded.
- start dropping in SYNC..CHK aborts to IDLE with no done pulse. RAM contents already written are left as-is.
- Bytes arriving in IDLE or WAIT_LOW are ignored. The receiver still runs so that it stays bit-aligned.
- idx is ADDR_W bits wide and cannot wrap because MAX_LEN < 2^ADDR_W.
- Reset: every output is 0 (ram_din, ram_addr, ram_we, done, err, rx_len). FSM is in IDLE, receiver idle, synchronizer flops are 1.

## Timing
- byte_valid is asserted the cycle after the stop-bit sample.
- ram_we/ram_din/ram_addr are registered and asserted the cycle after byte_valid, so each write is exactly one cycle.
- done/err are asserted the cycle after the CHK byte's byte_valid, or the cycle after the failing byte's byte_valid.
- Minimum gap between writes is 10*CLKS_PER_BIT cycles; no back-pressure is needed.
- Reset mid-frame takes effect immediately and asynchronously; the partial frame is lost.

## Structure
- Shared package uart_frame_pkg holds:
  - the FSM state enum (IDLE, SYNC, LEN_H, LEN_L, DATA, CHK, DONE, ERR, WAIT_LOW);
  - SYNC_BYTE;
  - MAX_LEN.
- Sub-module uart_rx_byte contains the synchronizer, baud counter and bit shifter. It outputs byte_valid, byte_data and frame_ok.
- The top file holds the frame FSM, the length/index/checksum registers and the RAM write port.

## Test plan
(Use CLK_FREQ=1000, BAUD=100, giving CLKS_PER_BIT=10.)
- Good frame: start=1; send A5 00 03 11 22 33 00. Required: writes (0,11) (1,22) (2,33); done=1, err=0; rx_len=3.
- Bad checksum: send A5 00 02 0F F0 01. Required: two writes occur; then done=1 with err=1.
- Noise before sync: send 3C 5A A5 00 01 7E 7E. Required: the leading bytes are ignored; one write (0,7E); done with err=0.
- Bad length: send A5 00 00, then separately A5 09 91. Required: no writes; done with err=1 after the LEN_L byte.
- Framing error: send A5 00 02 with the second payload byte's stop bit forced low. Required: one write, then done=1, err=1.
- Abort and reset:
  - Drop start after 2 payload bytes: no done pulse, FSM returns to IDLE.
  - Assert sys_rst_n=0 mid-byte: all outputs become 0 immediately.
  - A following good frame then completes with err=0.
